// File: rtl/rotm_pipe.sv
// rotm_pipe: pipelined rotate/shift-and-mask unit for the fixed-point path.
// Every mode runs through one left rotator plus a mask merge; shifts are a
// rotation with a generated mask and a fill value inserted under ~mask.
module rotm_pipe #(
  parameter int DWIDTH = 32,
  parameter int STAGES = 2,
  localparam int AW = $clog2(DWIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] x,
  input  logic [DWIDTH-1:0] q,
  input  logic [AW:0]       num,
  input  logic [AW-1:0]     mstart,
  input  logic [AW-1:0]     mstop,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DWIDTH-1:0] y,
  output logic              cout,
  output logic [3:0]        cr
);
  localparam logic [1:0] M_ROTM = 2'b00;
  localparam logic [1:0] M_SL   = 2'b01;
  localparam logic [1:0] M_SRA  = 2'b11;

  if (!(DWIDTH == 32 || DWIDTH == 64)) begin : g_bad_dwidth
    $error("rotm_pipe: DWIDTH must be 32 or 64");
  end
  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("rotm_pipe: STAGES must be 1 or 2");
  end

  logic              advance;
  logic [STAGES-1:0] vld_q, vld_d;

  assign valid_out = vld_q[STAGES-1];
  assign advance   = ~valid_out | ready_out;
  assign ready_in  = advance;

  // Valid bits move in lockstep with the data; a stall freezes every stage.
  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      vld_d    = vld_q << 1;
      vld_d[0] = valid_in;
    end
  end

  // Stage valid register.
  always_ff @(posedge clk or posedge reset)
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;

  // ---------------- front end: rotator and mask generator ----------------
  logic [AW-1:0]       rot_amt;
  logic [2*DWIDTH-1:0] rot_dbl;
  logic [DWIDTH-1:0]   rot_a, mask_a, ins_a, ones;
  logic                sign_a, sout_a;

  // Right shifts rotate left by (DWIDTH - n); num[AW] means "everything
  // shifted out", which simply empties the mask.
  always_comb begin
    ones    = '1;
    sign_a  = x[DWIDTH-1];
    rot_amt = num[AW-1:0];
    if (mode[1]) rot_amt = ~num[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
    rot_dbl = {x, x} << rot_amt;
    rot_a   = rot_dbl[2*DWIDTH-1:DWIDTH];
    mask_a  = '0;
    ins_a   = '0;
    case (mode)
      M_ROTM: begin
        // i is the PowerISA bit index (0 = MSB); stop < start wraps around
        for (int i = 0; i < DWIDTH; i++) begin
          if (mstart <= mstop)
            mask_a[DWIDTH-1-i] = (AW'(i) >= mstart) && (AW'(i) <= mstop);
          else
            mask_a[DWIDTH-1-i] = (AW'(i) >= mstart) || (AW'(i) <= mstop);
        end
        ins_a = q;
      end
      M_SL: mask_a = num[AW] ? '0 : ones << num[AW-1:0];
      default: begin
        mask_a = num[AW] ? '0 : ones >> num[AW-1:0];
        if (mode == M_SRA) ins_a = {DWIDTH{sign_a}};
      end
    endcase
    // bits rotated into the masked-off region are exactly the ones shifted out
    sout_a = |(rot_a & ~mask_a);
  end

  // ---------------- optional mid-pipe register ----------------
  logic [DWIDTH-1:0] b_rot, b_mask, b_ins;
  logic [1:0]        b_mode;
  logic              b_sign, b_sout;

  if (STAGES == 2) begin : g_s1
    logic [DWIDTH-1:0] rot_q, rot_d, mask_q, mask_d, ins_q, ins_d;
    logic [1:0]        mode_q, mode_d;
    logic              sign_q, sign_d, sout_q, sout_d;

    // Capture rotator/mask results when the pipe advances, else hold.
    always_comb begin
      rot_d  = rot_q;  mask_d = mask_q; ins_d  = ins_q;
      mode_d = mode_q; sign_d = sign_q; sout_d = sout_q;
      if (advance) begin
        rot_d  = rot_a;  mask_d = mask_a; ins_d  = ins_a;
        mode_d = mode;   sign_d = sign_a; sout_d = sout_a;
      end
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        rot_q  <= '0; mask_q <= '0; ins_q  <= '0;
        mode_q <= '0; sign_q <= 1'b0; sout_q <= 1'b0;
      end else begin
        rot_q  <= rot_d;  mask_q <= mask_d; ins_q  <= ins_d;
        mode_q <= mode_d; sign_q <= sign_d; sout_q <= sout_d;
      end

    assign b_rot  = rot_q;  assign b_mask = mask_q; assign b_ins  = ins_q;
    assign b_mode = mode_q; assign b_sign = sign_q; assign b_sout = sout_q;
  end else begin : g_s0
    assign b_rot  = rot_a;  assign b_mask = mask_a; assign b_ins  = ins_a;
    assign b_mode = mode;   assign b_sign = sign_a; assign b_sout = sout_a;
  end

  // ---------------- back end: merge, flags, output register ----------------
  logic [DWIDTH-1:0] y_q, y_d, y_new;
  logic [3:0]        cr_q, cr_d;
  logic              cout_q, cout_d, lt, eq;

  // Merge rotated data with the insert value and derive the condition field.
  always_comb begin
    y_new  = (b_rot & b_mask) | (b_ins & ~b_mask);
    lt     = y_new[DWIDTH-1];
    eq     = (y_new == '0);
    y_d    = y_q;
    cr_d   = cr_q;
    cout_d = cout_q;
    if (advance) begin
      y_d    = y_new;
      cr_d   = {lt, ~lt & ~eq, eq, 1'b0};
      cout_d = (b_mode == M_SRA) & b_sign & b_sout;
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      y_q <= '0; cr_q <= '0; cout_q <= 1'b0;
    end else begin
      y_q <= y_d; cr_q <= cr_d; cout_q <= cout_d;
    end

  assign y    = y_q;
  assign cr   = cr_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_rotm_pipe.sv
// tb_rotm_pipe: scoreboard bench for rotm_pipe (32-bit/2-stage main DUT,
// plus a 64-bit/1-stage instance for width and single-register checks).
module tb_rotm_pipe;
  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  cr;
    logic        cout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, ready_in, valid_out, ready_out, cout;
  logic [1:0]  mode;
  logic [31:0] x, q, y;
  logic [5:0]  num;
  logic [4:0]  mstart, mstop;
  logic [3:0]  cr;

  logic        v64_in, r64_in, v64_out, r64_out, cout64;
  logic [1:0]  mode64;
  logic [63:0] x64, q64, y64;
  logic [6:0]  num64;
  logic [5:0]  ms64, me64;
  logic [3:0]  cr64;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic        hold_v = 1'b0;
  logic [31:0] hold_y;
  logic [3:0]  hold_cr;
  logic        hold_c;

  always #5 clk = ~clk;

  rotm_pipe #(.DWIDTH(32), .STAGES(2)) u32 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .mode(mode), .x(x), .q(q), .num(num), .mstart(mstart), .mstop(mstop),
    .valid_out(valid_out), .ready_out(ready_out), .y(y), .cout(cout), .cr(cr));

  rotm_pipe #(.DWIDTH(64), .STAGES(1)) u64 (
    .clk(clk), .reset(reset), .valid_in(v64_in), .ready_in(r64_in),
    .mode(mode64), .x(x64), .q(q64), .num(num64), .mstart(ms64), .mstop(me64),
    .valid_out(v64_out), .ready_out(r64_out), .y(y64), .cout(cout64), .cr(cr64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model written directly from the operation definitions.
  function automatic exp_t model(input logic [1:0] m, input logic [31:0] xx, input logic [31:0] qq,
                                 input logic [5:0] n, input logic [4:0] ms, input logic [4:0] me);
    exp_t e;
    logic [31:0] mk, rot, low;
    logic [4:0]  r;
    e.cout = 1'b0;
    e.y    = '0;
    case (m)
      2'b00: begin
        r   = n[4:0];
        rot = (r == 5'd0) ? xx : ((xx << r) | (xx >> (6'd32 - {1'b0, r})));
        for (int i = 0; i < 32; i++) begin
          if (ms <= me) mk[31-i] = (i >= int'(ms)) && (i <= int'(me));
          else          mk[31-i] = (i >= int'(ms)) || (i <= int'(me));
        end
        e.y = (rot & mk) | (qq & ~mk);
      end
      2'b01: e.y = n[5] ? 32'd0 : xx << n;
      2'b10: e.y = n[5] ? 32'd0 : xx >> n;
      default: begin
        if (n[5]) begin
          e.y    = {32{xx[31]}};
          e.cout = xx[31] & (|xx);
        end else begin
          e.y    = 32'($signed(xx) >>> n);
          low    = (32'd1 << n) - 32'd1;
          e.cout = xx[31] & (|(xx & low));
        end
      end
    endcase
    e.cr = {e.y[31], ~e.y[31] & (e.y != 0), e.y == 0, 1'b0};
    return e;
  endfunction

  // Drive one op, wait for the accepting edge, record its expected result.
  task automatic issue(input logic [1:0] m, input logic [31:0] xx, input logic [31:0] qq,
                       input logic [5:0] n, input logic [4:0] ms, input logic [4:0] me);
    int g;
    mode = m; x = xx; q = qq; num = n; mstart = ms; mstop = me; valid_in = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!ready_in && g < 200);
    if (!ready_in) chk("issue_timeout", 64'(ready_in), 64'd1);
    else sb.push_back(model(m, xx, qq, n, ms, me));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic measure_lat(input string tag);
    int lat;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!valid_out && lat < 10);
    chk(tag, 64'(lat), 64'd2);
  endtask

  task automatic op64(input string tag, input logic [1:0] m, input logic [63:0] xx,
                      input logic [6:0] n, input logic [5:0] ms, input logic [5:0] me,
                      input logic [63:0] ey, input logic [3:0] ecr, input logic ec);
    mode64 = m; x64 = xx; num64 = n; ms64 = ms; me64 = me; v64_in = 1'b1;
    @(posedge clk); #1;
    v64_in = 1'b0;
    chk({tag, "_valid"}, 64'(v64_out), 64'd1);
    chk({tag, "_y"}, y64, ey);
    chk({tag, "_cr"}, 64'(cr64), 64'(ecr));
    chk({tag, "_cout"}, 64'(cout64), 64'(ec));
  endtask

  // Output monitor: pops on every transfer out, checks holds during stalls.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (hold_v) begin
        chk("stall_y_stable", 64'(y), 64'(hold_y));
        chk("stall_cr_stable", 64'(cr), 64'(hold_cr));
        chk("stall_cout_stable", 64'(cout), 64'(hold_c));
      end
      if (ready_out) begin
        hold_v = 1'b0;
        if (sb.size() == 0) chk("unexpected_out", 64'(valid_out), 64'd0);
        else begin
          mon_e = sb.pop_front();
          chk("out_y", 64'(y), 64'(mon_e.y));
          chk("out_cr", 64'(cr), 64'(mon_e.cr));
          chk("out_cout", 64'(cout), 64'(mon_e.cout));
          n_out++;
        end
      end else begin
        hold_v = 1'b1; hold_y = y; hold_cr = cr; hold_c = cout;
      end
    end else hold_v = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic done;
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    mode = '0; x = '0; q = '0; num = '0; mstart = '0; mstop = '0;
    v64_in = 1'b0; r64_out = 1'b1; mode64 = '0; x64 = '0; q64 = '0;
    num64 = '0; ms64 = '0; me64 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_cr", 64'(cr), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd1);
    chk("rst_y64", y64, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic rotate with full mask, latency and absolute value.
    issue(2'b00, 32'h12345678, 32'h0, 6'd8, 5'd0, 5'd31);
    measure_lat("lat_first");
    chk("t1_y_abs", 64'(y), 64'h34567812);
    chk("t1_cr_abs", 64'(cr), 64'b0100);
    @(posedge clk); #1;

    // Directed table, back-to-back.
    issue(2'b00, 32'hFFFFFFFF, 32'h0,        6'd0,  5'd28, 5'd3);
    issue(2'b00, 32'h000000AB, 32'h11111111, 6'd8,  5'd16, 5'd23);
    issue(2'b00, 32'hFFFFFFFF, 32'h0,        6'd40, 5'd5,  5'd5);
    issue(2'b11, 32'h80000001, 32'h0,        6'd1,  5'd0,  5'd0);
    issue(2'b11, 32'h80000001, 32'h0,        6'd32, 5'd0,  5'd0);
    issue(2'b11, 32'h40000000, 32'h0,        6'd4,  5'd0,  5'd0);
    issue(2'b11, 32'h80000000, 32'h0,        6'd0,  5'd0,  5'd0);
    issue(2'b01, 32'hDEADBEEF, 32'h0,        6'd32, 5'd0,  5'd0);
    issue(2'b10, 32'hDEADBEEF, 32'h0,        6'd31, 5'd0,  5'd0);
    issue(2'b10, 32'hDEADBEEF, 32'hFFFFFFFF, 6'd0,  5'd9,  5'd2);

    // Backpressure: four ops, 3-cycle stall after the first result.
    fork
      begin
        issue(2'b01, 32'h00000001, 32'h0, 6'd4,  5'd0, 5'd0);
        issue(2'b10, 32'hF0000000, 32'h0, 6'd8,  5'd0, 5'd0);
        issue(2'b11, 32'hF000000F, 32'h0, 6'd2,  5'd0, 5'd0);
        issue(2'b00, 32'hA5A5A5A5, 32'h0, 6'd16, 5'd8, 5'd15);
      end
      begin
        int g;
        g = 0;
        do begin @(posedge clk); #1; g++; end while (!valid_out && g < 20);
        chk("bp_first_result", 64'(valid_out), 64'd1);
        ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_ready_in", 64'(ready_in), 64'd0);
          @(posedge clk); #1;
        end
        ready_out = 1'b1;
        base = n_out;
        repeat (4) @(negedge clk);
        #1 chk("bp_throughput", 64'(n_out - base), 64'd4);
      end
    join
    for (int g = 0; g < 100 && sb.size() != 0; g++) @(negedge clk);
    #1 chk("bp_drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Reset with two ops in flight.
    issue(2'b01, 32'h0000FFFF, 32'h0, 6'd3, 5'd0, 5'd0);
    issue(2'b01, 32'h0000FFFF, 32'h0, 6'd5, 5'd0, 5'd0);
    chk("pre_rst_valid", 64'(valid_out), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_y", 64'(y), 64'd0);
    chk("mid_rst_cr", 64'(cr), 64'd0);
    chk("mid_rst_cout", 64'(cout), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(valid_out), 64'd0);
    issue(2'b00, 32'hCAFEBABE, 32'h0, 6'd4, 5'd0, 5'd31);
    measure_lat("lat_after_reset");
    @(posedge clk); #1;

    // Random ops with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          issue(2'($urandom_range(0, 3)), $urandom, $urandom, 6'($urandom_range(0, 63)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_out = ($urandom_range(0, 3) != 0);
        end
        ready_out = 1'b1;
      end
    join
    for (int g = 0; g < 200 && sb.size() != 0; g++) @(negedge clk);
    #1 chk("rand_drain", 64'(sb.size()), 64'd0);

    // 64-bit, single-register instance.
    @(posedge clk); #1;
    op64("w64_rotm", 2'b00, 64'h00000000FFFFFFFF, 7'd32, 6'd0, 6'd63,
         64'hFFFFFFFF00000000, 4'b1000, 1'b0);
    op64("w64_sra64", 2'b11, 64'h8000000000000001, 7'd64, 6'd0, 6'd0,
         64'hFFFFFFFFFFFFFFFF, 4'b1000, 1'b1);
    op64("w64_sl63", 2'b01, 64'h0000000000000003, 7'd63, 6'd0, 6'd0,
         64'h8000000000000000, 4'b1000, 1'b0);
    op64("w64_sr127", 2'b10, 64'hFFFFFFFFFFFFFFFF, 7'd127, 6'd0, 6'd0,
         64'h0, 4'b0010, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rotm_pipe.md
Name: rotm_pipe

Overview:
- Pipelined, parametrised rotate/shift-and-mask unit for the fixed-point execution path.
- Generalises the combinational 32-bit rotate-and-mask:
  - DWIDTH is a parameter (32 or 64).
  - Adds logical and algebraic shift modes with a carry-out.
  - Adds 1 or 2 register stages with valid/ready handshake and stall support.
- Sits between the issue stage and the writeback mux.
- Bit numbering for mstart/mstop is PowerISA: bit 0 is the MSB.

Parameters:
DWIDTH, 32, data width; legal values 32 or 64; AW = log2(DWIDTH)
STAGES, 2, pipeline depth; 1 = single output register, 2 = rotate/mask register followed by merge/flags register

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
valid_in  input  1  operation present
ready_in  output  1  unit can accept an operation this cycle
mode  input  2  00 ROTM (rotate-mask-insert), 01 SL, 10 SR, 11 SRA
x  input  DWIDTH  source operand
q  input  DWIDTH  insert operand (ROTM only)
num  input  AW+1  rotate/shift amount; ROTM uses num[AW-1:0]
mstart  input  AW  mask start (ROTM only)
mstop  input  AW  mask stop (ROTM only)
valid_out  output  1  result present
ready_out  input  1  consumer accepts the result
y  output  DWIDTH  result
cout  output  1  carry (SRA only; 0 in all other modes)
cr  output  4  condition field {lt, gt, eq, so}; so is always 0

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - all stage valid bits clear, so valid_out=0;
  - y=0, cr=0, cout=0;
  - in-flight operations are discarded, with no partial output.
- Handshake:
  - advance = ~valid_out | ready_out; ready_in = advance.
  - All stages shift together when advance=1; otherwise all stages hold.
  - Bubbles are not compressed.
  - Transfer in occurs when valid_in & ready_in; transfer out occurs when valid_out & ready_out.
  - A simultaneous in and out transfer in one cycle is legal and sustains 1 op/cycle.
  - y/cr/cout stay stable while valid_out=1 and ready_out=0.
- Latency: exactly STAGES cycles from input transfer to valid_out, absent stall. Operations complete in issue order.
- ROTM:
  - rotated = x rotated left by num[AW-1:0].
  - Mask:
    - if mstart <= mstop, ones from mstart to mstop inclusive;
    - else wrapped mask: ones from mstart to DWIDTH-1 and from 0 to mstop.
    - mstart == mstop gives a single bit.
  - y = (rotated & mask) | (q & ~mask).
  - num[AW] is ignored.
- SL: y = x << num. If num >= DWIDTH, y = 0.
- SR: y = x >> num (logical). If num >= DWIDTH, y = 0.
- SRA:
  - y = x >> num with sign fill. If num >= DWIDTH, y is all copies of the sign bit.
  - cout = sign & (any 1 bit shifted out). For num >= DWIDTH this means sign & (|x).
  - num = 0 gives cout = 0.
- Shift modes ignore q, mstart and mstop. Shifts are implemented on the rotator with a generated mask, not a separate shifter.
- cr on y (full width):
  - lt = y[MSB];
  - eq = (y == 0);
  - gt = ~lt & ~eq.
- STAGES=2 split:
  - stage 1 registers rotated, mask, q, mode, the sign bit and the shifted-out-ones flag;
  - stage 2 registers y, cr, cout.
- STAGES=1: all logic feeds a single output register.
- Illegal DWIDTH or STAGES values: elaboration-time $error.

Test Plan:
- ROTM, DWIDTH=32, x=0x12345678, num=8, mstart=0, mstop=31, q=0 -> y=0x34567812, cr=gt, cout=0, valid_out exactly STAGES cycles after input.
- ROTM wrapped mask: x=0xFFFFFFFF, num=0, mstart=28, mstop=3, q=0 -> y=0xF000000F, cr=lt. Insert case: x=0x000000AB, num=8, mstart=16, mstop=23, q=0x11111111 -> y=0x1111AB11.
- SRA: x=0x80000001, num=1 -> y=0xC0000000, cout=1. Same x, num=32 -> y=0xFFFFFFFF, cout=1. x=0x40000000, num=4 -> y=0x04000000, cout=0.
- SL/SR bounds: x=0xDEADBEEF, SL num=32 -> y=0, cr=eq. SR num=31 -> y=0x00000001. DWIDTH=64 ROTM num=32 on 0x00000000FFFFFFFF with full mask -> 0xFFFFFFFF00000000.
- Backpressure: issue 4 back-to-back ops, hold ready_out=0 for 3 cycles after the first result -> ready_in=0 during the stall, outputs stable, all 4 results delivered in order with no loss or duplication, then 1/cycle throughput.
- Reset mid-operation: assert reset with 2 ops in flight -> valid_out=0 and y/cr/cout=0 immediately (asynchronous). After release, a new op yields a correct result at latency STAGES.
